instr_fetch_sequencer: RTL and testbench
========================================

Name: instr_fetch_sequencer

Overview:
Fetch and timing front end of the RISC control path. It fetches 16-bit instructions over a req/ack memory handshake and holds them in the instruction register. It drives the 4-bit opcode field and a 4-bit timing count (sequence counter); each feeds a 4-to-16 one-hot decoder stage. It runs the instruction timing steps T0..T15 until the control logic signals end of instruction.

Parameters:
ADDR_WIDTH, 12, width of PC / memory address; PC wraps modulo 2^ADDR_WIDTH
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 255, max cycles mem_req may stay high without mem_ack before fault (1..65535)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  level; permits starting a new fetch
mem_req  out  1  fetch request, registered
mem_addr  out  ADDR_WIDTH  fetch address (= pc while mem_req=1, else 0)
mem_rdata  in  16  instruction word, valid when mem_ack=1
mem_ack  in  1  one-cycle fetch acknowledge
sc_clr  in  1  end of instruction from control logic (honoured only in EXEC)
halt_req  in  1  halt after current instruction (sampled with sc_clr)
pc_load  in  1  branch taken (sampled with sc_clr)
pc_load_val  in  ADDR_WIDTH  branch target
ir  out  16  instruction register
opcode  out  4  ir[15:12], to opcode decoder
t_count  out  4  sequence counter, to timing decoder; 0 outside EXEC
pc  out  ADDR_WIDTH  program counter
instr_valid  out  1  high throughout EXEC
halted  out  1  sticky; high in HALTED
fault  out  1  sticky; overflow or fetch timeout

Behaviour:
- Reset: state IDLE; pc=RESET_PC; ir=0; sc=0; wait counter=0; mem_req=0; instr_valid=0; halted=0; fault=0. Reset overrides everything, including mid-fetch and mid-EXEC; any in-flight mem_ack in the reset cycle is ignored.
- States: IDLE, FETCH, EXEC, HALTED. All outputs are registered or direct decodes of registered state.
- IDLE: run=1 at edge -> FETCH; mem_req=1 from the next cycle.
- FETCH: mem_req=1, mem_addr=pc, wait counter increments each cycle.
  - mem_ack=1 at an edge: ir<=mem_rdata; pc<=pc+1 (wraps all-ones->0); sc<=0; wait counter<=0; -> EXEC.
  - The cycle after ack: mem_req=0, instr_valid=1, t_count=0.
  - Wait counter reaching TIMEOUT with no ack: fault<=1 -> HALTED.
  - Minimum fetch latency is 1 cycle (ack in the first req cycle).
- EXEC: sc increments by 1 each cycle while sc_clr=0.
  - sc_clr=1: sc<=0, instr_valid<=0.
  - If pc_load=1, pc<=pc_load_val; this has priority over the increment already applied at fetch.
  - Next state: halt_req=1 -> HALTED; else run=1 -> FETCH (back-to-back, no idle cycle); else IDLE.
  - sc=15 with sc_clr=0: fault<=1 -> HALTED. No wrap to 0.
  - sc_clr at sc=15 is legal and takes priority over the fault.
- pc_load/halt_req without sc_clr, sc_clr outside EXEC, and mem_ack outside FETCH are all ignored with no state change.
- HALTED: mem_req=0, instr_valid=0, t_count=0, halted=1. ir and pc hold. Exit only via rst.
- opcode always equals ir[15:12]; ir holds its last value in IDLE, FETCH and HALTED.

Test Plan:
- Reset: assert rst 2 cycles with run=1 -> pc=0, ir=0, mem_req=0, t_count=0, halted=0, fault=0.
- Fetch with wait: run=1, mem_ack 3 cycles after mem_req rises, mem_rdata=16'h7A05 -> mem_addr=0 during req; next cycle ir=16'h7A05, opcode=4'h7, pc=1, instr_valid=1, t_count=0.
- Timing and branch: in EXEC hold sc_clr=0 for 4 cycles -> t_count 0,1,2,3. Then sc_clr=1 with pc_load=1, pc_load_val=12'h3F0 -> pc=12'h3F0, next mem_addr=12'h3F0, no idle cycle.
- Overflow fault: never assert sc_clr -> t_count reaches 15, then fault=1, halted=1, mem_req stays 0; mem_ack pulses ignored.
- Fetch timeout (TIMEOUT=4): no mem_ack -> mem_req high 4 cycles, then fault=1, halted=1.
- Reset mid-operation and PC wrap: rst during FETCH with a simultaneous mem_ack -> ir=0, pc=RESET_PC. Separately, pc=12'hFFF fetch -> pc becomes 12'h000.

Source files
------------

// File: rtl/instr_fetch_sequencer_if.sv
// instr_fetch_sequencer_if: req/ack instruction memory bus between the fetch sequencer and memory
interface instr_fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 12
) ();
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: fetches instructions over req/ack and sequences timing steps T0..T15
module instr_fetch_sequencer #(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  sc_clr,
    input  logic                  halt_req,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    instr_fetch_sequencer_if.master bus,
    output logic [15:0]           ir,
    output logic [3:0]            opcode,
    output logic [3:0]            t_count,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  instr_valid,
    output logic                  halted,
    output logic                  fault
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

    // The wait counter has counted TIMEOUT-1 idle request cycles when this matches,
    // so the next unacknowledged edge is the TIMEOUT-th request cycle.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc_n;
    logic [15:0]           ir_n;
    logic [3:0]            sc, sc_n;
    logic [15:0]           wait_cnt, wait_n;
    logic                  fault_n;

    // State and datapath registers; reset wins over any in-flight handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            sc       <= '0;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            sc       <= sc_n;
            wait_cnt <= wait_n;
            fault    <= fault_n;
        end
    end

    // Next-state logic: fetch handshake, timeout, timing count and end-of-instruction
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        sc_n    = sc;
        wait_n  = wait_cnt;
        fault_n = fault;
        case (state)
            IDLE: begin
                if (run) begin
                    state_n = FETCH;
                    wait_n  = '0;
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    ir_n    = bus.mem_rdata;
                    pc_n    = pc + ADDR_WIDTH'(1);
                    sc_n    = '0;
                    wait_n  = '0;
                    state_n = EXEC;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault_n = 1'b1;
                    state_n = HALTED;
                end else begin
                    wait_n = wait_cnt + 16'd1;
                end
            end
            EXEC: begin
                if (sc_clr) begin
                    sc_n    = '0;
                    pc_n    = pc_load ? pc_load_val : pc;
                    state_n = halt_req ? HALTED : (run ? FETCH : IDLE);
                    wait_n  = '0;
                end else if (sc == 4'hF) begin
                    fault_n = 1'b1;
                    state_n = HALTED;
                end else begin
                    sc_n = sc + 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_req  = (state == FETCH);
    assign bus.mem_addr = (state == FETCH) ? pc : '0;
    assign opcode       = ir[15:12];
    assign t_count      = (state == EXEC) ? sc : 4'd0;
    assign instr_valid  = (state == EXEC);
    assign halted       = (state == HALTED);
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: randomized self-checking bench against a transaction-level model
module tb_instr_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        sc_clr = 1'b0;
    logic        halt_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [11:0] pc_load_val = '0;
    logic [15:0] ir;
    logic [3:0]  opcode, t_count;
    logic [11:0] pc;
    logic        instr_valid, halted, fault;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [11:0] m_pc;
    logic [15:0] m_ir;

    instr_fetch_sequencer_if #(.ADDR_WIDTH(12)) bus ();

    instr_fetch_sequencer #(.ADDR_WIDTH(12), .RESET_PC(12'h000), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .run(run), .sc_clr(sc_clr), .halt_req(halt_req),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .bus(bus),
        .ir(ir), .opcode(opcode), .t_count(t_count), .pc(pc),
        .instr_valid(instr_valid), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 0; sc_clr = 0; halt_req = 0; pc_load = 0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        step(); step();
        rst = 1'b0;
        m_pc = 12'h000;
        m_ir = 16'h0000;
    endtask

    task automatic start_fetch();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    // Serve one fetch whose ack arrives in request cycle 'lat' (1 = same cycle as req rises)
    task automatic serve(input logic [15:0] w, input int lat);
        for (int i = 0; i < lat; i++) begin
            n_tests++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== m_pc) begin
                n_fail++;
                $display("FAIL fetch_req cyc=%0d got req=%b addr=%h exp req=1 addr=%h", i, bus.mem_req, bus.mem_addr, m_pc);
            end
            bus.mem_ack = (i == lat - 1);
            bus.mem_rdata = (i == lat - 1) ? w : 16'($urandom);
            sc_clr = 1'($urandom);
            step();
        end
        bus.mem_ack = 1'b0;
        sc_clr = 1'b0;
        m_ir = w;
        m_pc = m_pc + 12'd1;
        n_tests++;
        if (ir !== m_ir || opcode !== m_ir[15:12] || pc !== m_pc || instr_valid !== 1'b1 ||
            t_count !== 4'd0 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_done got ir=%h op=%h pc=%h iv=%b t=%0d req=%b exp ir=%h op=%h pc=%h iv=1 t=0 req=0",
                     ir, opcode, pc, instr_valid, t_count, bus.mem_req, m_ir, m_ir[15:12], m_pc);
        end
    endtask

    // Run n timing steps, then end the instruction with sc_clr and the given controls
    task automatic exec_instr(input int n, input bit ld, input logic [11:0] tgt, input bit go, input bit hr);
        bit exp_req;
        for (int k = 0; k < n; k++) begin
            n_tests++;
            if (t_count !== 4'(k) || instr_valid !== 1'b1 || bus.mem_req !== 1'b0 ||
                bus.mem_addr !== 12'h000 || pc !== m_pc || halted !== 1'b0) begin
                n_fail++;
                $display("FAIL exec_step k=%0d got t=%0d iv=%b req=%b addr=%h pc=%h hlt=%b exp t=%0d iv=1 req=0 addr=000 pc=%h hlt=0",
                         k, t_count, instr_valid, bus.mem_req, bus.mem_addr, pc, halted, k, m_pc);
            end
            sc_clr = 1'b0;
            pc_load = 1'($urandom);
            halt_req = 1'($urandom);
            run = 1'($urandom);
            pc_load_val = 12'($urandom);
            bus.mem_ack = 1'($urandom);
            step();
        end
        bus.mem_ack = 1'b0;
        n_tests++;
        if (t_count !== 4'(n) || ir !== m_ir) begin
            n_fail++;
            $display("FAIL exec_last got t=%0d ir=%h exp t=%0d ir=%h", t_count, ir, n, m_ir);
        end
        sc_clr = 1'b1; pc_load = ld; pc_load_val = tgt; run = go; halt_req = hr;
        step();
        sc_clr = 1'b0; pc_load = 1'b0; run = 1'b0; halt_req = 1'b0;
        if (ld) m_pc = tgt;
        exp_req = go && !hr;
        n_tests++;
        if (pc !== m_pc || instr_valid !== 1'b0 || t_count !== 4'd0 || halted !== hr ||
            bus.mem_req !== exp_req || bus.mem_addr !== (exp_req ? m_pc : 12'h000) || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_end got pc=%h iv=%b t=%0d hlt=%b req=%b addr=%h flt=%b exp pc=%h iv=0 t=0 hlt=%b req=%b addr=%h flt=0",
                     pc, instr_valid, t_count, halted, bus.mem_req, bus.mem_addr, fault,
                     m_pc, hr, exp_req, exp_req ? m_pc : 12'h000);
        end
    endtask

    task automatic test_reset();
        run = 1'b1; rst = 1'b1;
        step(); step();
        n_tests++;
        if (pc !== 12'h000 || ir !== 16'h0000 || bus.mem_req !== 1'b0 || t_count !== 4'd0 ||
            halted !== 1'b0 || fault !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset got pc=%h ir=%h req=%b t=%0d hlt=%b flt=%b iv=%b exp all zero",
                     pc, ir, bus.mem_req, t_count, halted, fault, instr_valid);
        end
        do_reset();
    endtask

    task automatic test_idle_ignored();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = 16'($urandom);
            sc_clr = 1'b1; pc_load = 1'b1; pc_load_val = 12'($urandom); halt_req = 1'b1;
            step();
            n_tests++;
            if (pc !== m_pc || ir !== m_ir || bus.mem_req !== 1'b0 || halted !== 1'b0 || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ignore got pc=%h ir=%h req=%b hlt=%b iv=%b exp pc=%h ir=%h req=0 hlt=0 iv=0",
                         pc, ir, bus.mem_req, halted, instr_valid, m_pc, m_ir);
            end
        end
        bus.mem_ack = 0; sc_clr = 0; pc_load = 0; halt_req = 0;
    endtask

    task automatic test_fetch_branch();
        do_reset();
        start_fetch();
        serve(16'h7A05, 4);
        exec_instr(4, 1'b1, 12'h3F0, 1'b1, 1'b0);
        serve(16'($urandom), $urandom_range(1, 4));
        exec_instr($urandom_range(0, 15), 1'b0, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_fetch();
        for (int i = 0; i < 24; i++) begin
            serve(16'($urandom), $urandom_range(1, 4));
            exec_instr((i == 0) ? 15 : $urandom_range(0, 15), 1'($urandom), 12'($urandom), i != 23, 1'b0);
        end
    endtask

    task automatic test_halt();
        do_reset();
        start_fetch();
        serve(16'($urandom), 2);
        exec_instr(2, 1'b1, 12'h155, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            run = 1'b1; bus.mem_ack = 1'b1; sc_clr = 1'b1;
            step();
            n_tests++;
            if (halted !== 1'b1 || bus.mem_req !== 1'b0 || pc !== 12'h155 || ir !== m_ir || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold got hlt=%b req=%b pc=%h ir=%h flt=%b exp hlt=1 req=0 pc=155 ir=%h flt=0",
                         halted, bus.mem_req, pc, ir, fault, m_ir);
            end
        end
        run = 0; bus.mem_ack = 0; sc_clr = 0;
    endtask

    task automatic test_overflow();
        do_reset();
        start_fetch();
        serve(16'($urandom), 1);
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if (t_count !== 4'(k) || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL ovf_count got t=%0d flt=%b exp t=%0d flt=0", t_count, fault, k);
            end
            sc_clr = 1'b0;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (fault !== 1'b1 || halted !== 1'b1 || bus.mem_req !== 1'b0 || t_count !== 4'd0 ||
                instr_valid !== 1'b0 || pc !== m_pc || ir !== m_ir) begin
                n_fail++;
                $display("FAIL ovf_fault got flt=%b hlt=%b req=%b t=%0d iv=%b pc=%h ir=%h exp flt=1 hlt=1 req=0 t=0 iv=0 pc=%h ir=%h",
                         fault, halted, bus.mem_req, t_count, instr_valid, pc, ir, m_pc, m_ir);
            end
            run = 1'b1; bus.mem_ack = 1'($urandom); bus.mem_rdata = 16'($urandom); sc_clr = 1'($urandom);
            step();
        end
        run = 0; bus.mem_ack = 0; sc_clr = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        start_fetch();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus.mem_req !== 1'b1 || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_req cyc=%0d got req=%b flt=%b exp req=1 flt=0", i, bus.mem_req, fault);
            end
            step();
        end
        n_tests++;
        if (fault !== 1'b1 || halted !== 1'b1 || bus.mem_req !== 1'b0 || pc !== m_pc) begin
            n_fail++;
            $display("FAIL timeout_fault got flt=%b hlt=%b req=%b pc=%h exp flt=1 hlt=1 req=0 pc=%h",
                     fault, halted, bus.mem_req, pc, m_pc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_fetch();
        serve(16'hB3C1, 1);
        exec_instr(1, 1'b0, 12'h000, 1'b1, 1'b0);
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 16'hFFFF;
        step();
        rst = 1'b0; bus.mem_ack = 1'b0;
        n_tests++;
        if (ir !== 16'h0000 || pc !== 12'h000 || bus.mem_req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got ir=%h pc=%h req=%b iv=%b flt=%b exp ir=0000 pc=000 req=0 iv=0 flt=0",
                     ir, pc, bus.mem_req, instr_valid, fault);
        end
        m_pc = 12'h000; m_ir = 16'h0000;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        start_fetch();
        serve(16'($urandom), 1);
        exec_instr(0, 1'b1, 12'hFFF, 1'b1, 1'b0);
        serve(16'($urandom), 3);
        n_tests++;
        if (pc !== 12'h000) begin
            n_fail++;
            $display("FAIL pc_wrap got pc=%h exp pc=000", pc);
        end
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        m_pc = 12'h000;
        m_ir = 16'h0000;
        test_reset();
        test_idle_ignored();
        test_fetch_branch();
        test_back_to_back();
        test_halt();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
